// File: rtl/sm_debug_ctrl_pkg.sv
// Command opcodes and FSM state encodings shared by the sm_cpu debug controller
// and anything that drives its host command port.
package sm_debug_ctrl_pkg;

    typedef logic [2:0] cmd_op_t;

    localparam cmd_op_t CMD_NOP      = 3'd0;
    localparam cmd_op_t CMD_HALT     = 3'd1;
    localparam cmd_op_t CMD_RUN      = 3'd2;
    localparam cmd_op_t CMD_STEP     = 3'd3;
    localparam cmd_op_t CMD_SET_BP   = 3'd4;
    localparam cmd_op_t CMD_CLR_BP   = 3'd5;
    localparam cmd_op_t CMD_READ_REG = 3'd6;
    localparam cmd_op_t CMD_CLR_CYC  = 3'd7;

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    function automatic logic st_active(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/sm_debug_ctrl.sv
// Run/halt/step controller for sm_cpu: clock-enable gating, PC breakpoint,
// debug register port arbitration (host read vs. display scanner), cycle counter.
module sm_debug_ctrl
    import sm_debug_ctrl_pkg::*;
#(
    parameter bit RESET_RUN = 1'b1,
    parameter int STEP_W    = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    // Host command handshake: a command transfers on a cycle where
    // cmdValid && cmdReady; cmdReady does not depend on cmdValid.
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [2:0]       cmdOp,
    input  logic [31:0]      cmdArg,
    output logic             rspValid,
    output logic [31:0]      rspData,
    input  logic [31:0]      pc,
    output logic             cpuEn,
    output logic [4:0]       dbgRegAddr,
    input  logic [31:0]      dbgRegData,
    input  logic [4:0]       dispAddr,
    output logic [31:0]      dispData,
    output logic             halted,
    output logic [CNT_W-1:0] cycleCnt,
    output logic [1:0]       dbgState
);

    localparam logic [1:0] ST_RESET = RESET_RUN ? ST_RUN : ST_HALT;

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_left_q, step_left_d;
    logic [31:0]       bp_addr_q, bp_addr_d;
    logic              bp_en_q, bp_en_d;
    logic              bp_skip_q, bp_skip_d;
    logic              rd_cap_q, rd_cap_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [31:0]       disp_data_q, disp_data_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;

    logic              cmd_fire;
    logic              bp_hit;
    logic              cpu_en;
    logic [STEP_W-1:0] step_load;

    assign cmdReady  = !(rd_cap_q || rsp_valid_q);
    assign cmd_fire  = cmdValid && cmdReady;
    // The breakpoint instruction itself is never executed unless we are resuming from it.
    assign bp_hit    = bp_en_q && (pc == bp_addr_q) && !bp_skip_q;
    assign cpu_en    = st_active(state_q) && !bp_hit;
    assign step_load = (cmdArg[STEP_W-1:0] == '0) ? STEP_W'(1) : cmdArg[STEP_W-1:0];

    always_comb begin
        state_d     = state_q;
        step_left_d = step_left_q;
        bp_addr_d   = bp_addr_q;
        bp_en_d     = bp_en_q;
        cyc_d       = cpu_en ? cyc_q + CNT_W'(1) : cyc_q;

        if (state_q == ST_STEP && cpu_en) begin
            step_left_d = step_left_q - STEP_W'(1);
            if (step_left_q == STEP_W'(1)) state_d = ST_HALT;
        end
        if (bp_hit) state_d = ST_HALT;

        if (cmd_fire) begin
            case (cmdOp)
                CMD_HALT:    state_d = ST_HALT;
                CMD_RUN:     state_d = ST_RUN;
                CMD_STEP: begin
                    state_d     = ST_STEP;
                    step_left_d = step_load;
                end
                CMD_SET_BP: begin
                    bp_addr_d = cmdArg;
                    bp_en_d   = 1'b1;
                end
                CMD_CLR_BP:  bp_en_d = 1'b0;
                CMD_CLR_CYC: cyc_d   = '0;
                default: ;
            endcase
        end

        bp_skip_d = bp_skip_q;
        if (cpu_en) bp_skip_d = 1'b0;
        if (state_q == ST_HALT && state_d != ST_HALT) bp_skip_d = 1'b1;

        rd_cap_d    = cmd_fire && (cmdOp == CMD_READ_REG);
        rd_addr_d   = rd_cap_d ? cmdArg[4:0] : rd_addr_q;
        rsp_valid_d = rd_cap_q;
        rsp_data_d  = rd_cap_q ? dbgRegData : rsp_data_q;
        // Host read owns the port this cycle; the scanner keeps its last value.
        disp_data_d = rd_cap_q ? disp_data_q : dbgRegData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            step_left_q <= '0;
            bp_addr_q   <= '0;
            bp_en_q     <= 1'b0;
            bp_skip_q   <= 1'b0;
            rd_cap_q    <= 1'b0;
            rd_addr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            disp_data_q <= '0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_left_q <= step_left_d;
            bp_addr_q   <= bp_addr_d;
            bp_en_q     <= bp_en_d;
            bp_skip_q   <= bp_skip_d;
            rd_cap_q    <= rd_cap_d;
            rd_addr_q   <= rd_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            disp_data_q <= disp_data_d;
            cyc_q       <= cyc_d;
        end
    end

    assign dbgRegAddr = rd_cap_q ? rd_addr_q : dispAddr;
    assign cpuEn      = cpu_en;
    assign rspValid   = rsp_valid_q;
    assign rspData    = rsp_data_q;
    assign dispData   = disp_data_q;
    assign halted     = (state_q == ST_HALT);
    assign cycleCnt   = cyc_q;
    assign dbgState   = state_q;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Directed bench for sm_debug_ctrl: per-cycle vector table for run/step/breakpoint,
// hand-written sequences for reads, counter wrap and asynchronous reset.
module tb_sm_debug_ctrl;
    import sm_debug_ctrl_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // DUT under test: leaves reset halted, small counter so wrap is reachable
    logic        cmd_valid, cmd_ready;
    cmd_op_t     cmd_op;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] pc;
    logic        cpu_en;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] reg_data;
    logic [4:0]  disp_addr;
    logic [31:0] disp_data;
    logic        halted;
    logic [7:0]  cycle_cnt;
    logic [1:0]  dbg_state;

    // second instance: leaves reset running
    logic        r_cmd_ready, r_rsp_valid, r_cpu_en, r_halted;
    logic [31:0] r_rsp_data, r_disp_data, r_cycle_cnt;
    logic [4:0]  r_dbg_reg_addr;
    logic [1:0]  r_dbg_state;

    logic [31:0] regs [32];
    always_comb reg_data = (dbg_reg_addr == 5'd0) ? pc : regs[dbg_reg_addr];

    sm_debug_ctrl #(.RESET_RUN(1'b0), .STEP_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmdValid(cmd_valid), .cmdReady(cmd_ready), .cmdOp(cmd_op),
        .cmdArg(cmd_arg), .rspValid(rsp_valid), .rspData(rsp_data), .pc(pc), .cpuEn(cpu_en),
        .dbgRegAddr(dbg_reg_addr), .dbgRegData(reg_data), .dispAddr(disp_addr), .dispData(disp_data),
        .halted(halted), .cycleCnt(cycle_cnt), .dbgState(dbg_state)
    );

    sm_debug_ctrl #(.RESET_RUN(1'b1)) dut_run (
        .clk(clk), .rst_n(rst_n), .cmdValid(1'b0), .cmdReady(r_cmd_ready), .cmdOp(3'd0),
        .cmdArg(32'd0), .rspValid(r_rsp_valid), .rspData(r_rsp_data), .pc(pc), .cpuEn(r_cpu_en),
        .dbgRegAddr(r_dbg_reg_addr), .dbgRegData(32'd0), .dispAddr(5'd0), .dispData(r_disp_data),
        .halted(r_halted), .cycleCnt(r_cycle_cnt), .dbgState(r_dbg_state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: expected READ_REG results in issue order
    logic [31:0] exp_q [$];
    always @(negedge clk) begin
        if (rsp_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rspValid=%b data %0h, expected no response", rsp_valid, rsp_data);
            end else begin
                chk("rsp_data_sb", rsp_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic drive(input logic v, input cmd_op_t op, input logic [31:0] arg);
        cmd_valid = v;
        cmd_op    = op;
        cmd_arg   = arg;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        v;
        cmd_op_t     op;
        logic [31:0] arg;
        logic [31:0] pc;
        logic        en;
        logic        h;
    } vec_t;

    vec_t vq [$];

    function automatic vec_t mk(input logic v, input cmd_op_t op, input logic [31:0] arg,
                                input logic [31:0] p, input logic en, input logic h);
        vec_t r;
        r.v = v; r.op = op; r.arg = arg; r.pc = p; r.en = en; r.h = h;
        return r;
    endfunction

    logic [7:0] exp_cyc;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = {4{8'(i)}};
        regs[5] = 32'hDEADBEEF;

        //             v  op            arg       pc     en h
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h10, 0, 1));
        vq.push_back(mk(1, CMD_STEP,     32'd3,    32'h10, 0, 1));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h10, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h11, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h12, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h13, 0, 1));
        vq.push_back(mk(1, CMD_STEP,     32'd0,    32'h13, 0, 1));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h13, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h14, 0, 1));
        vq.push_back(mk(1, CMD_SET_BP,   32'h20,   32'h14, 0, 1));
        vq.push_back(mk(1, CMD_RUN,      32'd0,    32'h00, 0, 1));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h1E, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h1F, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 0, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 0, 1));
        vq.push_back(mk(1, CMD_RUN,      32'd0,    32'h20, 0, 1));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h21, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 0, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 0, 1));
        vq.push_back(mk(1, CMD_STEP,     32'd5,    32'h20, 0, 1));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h21, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 0, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 0, 1));
        vq.push_back(mk(1, CMD_CLR_BP,   32'd0,    32'h20, 0, 1));
        vq.push_back(mk(1, CMD_RUN,      32'd0,    32'h20, 0, 1));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h20, 1, 0));
        vq.push_back(mk(1, CMD_STEP,     32'd2,    32'h21, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h22, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h23, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h24, 0, 1));
        vq.push_back(mk(1, CMD_RUN,      32'd0,    32'h24, 0, 1));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h24, 1, 0));
        vq.push_back(mk(1, CMD_CLR_CYC,  32'd0,    32'h25, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h26, 1, 0));
        vq.push_back(mk(1, CMD_HALT,     32'd0,    32'h27, 1, 0));
        vq.push_back(mk(0, CMD_NOP,      32'd0,    32'h28, 0, 1));

        // reset
        rst_n = 1'b0;
        drive(1'b0, CMD_NOP, 32'd0);
        pc = 32'd0;
        disp_addr = 5'd3;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_cpuEn",    32'(cpu_en), 32'd0);
        chk("rst_halted",   32'(halted), 32'd1);
        chk("rst_cycleCnt", 32'(cycle_cnt), 32'd0);
        chk("rst_cmdReady", 32'(cmd_ready), 32'd1);
        chk("rst_dispData", disp_data, 32'd0);
        chk("rst_rspData",  rsp_data, 32'd0);
        chk("rst_state",    32'(dbg_state), 32'(ST_HALT));
        next_cycle();
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        chk("run_rst_cpuEn",  32'(r_cpu_en), 32'd1);
        chk("run_rst_halted", 32'(r_halted), 32'd0);
        chk("rel_cpuEn",      32'(cpu_en), 32'd0);
        chk("rel_halted",     32'(halted), 32'd1);
        chk("rel_dispData",   disp_data, 32'h03030303);

        // vector table
        exp_cyc = 8'd0;
        for (int i = 0; i < vq.size(); i++) begin
            next_cycle();
            drive(vq[i].v, vq[i].op, vq[i].arg);
            pc = vq[i].pc;
            #2;
            chk($sformatf("row%0d_cpuEn", i),    32'(cpu_en), 32'(vq[i].en));
            chk($sformatf("row%0d_halted", i),   32'(halted), 32'(vq[i].h));
            chk($sformatf("row%0d_cycleCnt", i), 32'(cycle_cnt), 32'(exp_cyc));
            chk($sformatf("row%0d_cmdReady", i), 32'(cmd_ready), 32'd1);
            if (vq[i].en) exp_cyc = exp_cyc + 8'd1;
            if (vq[i].v && vq[i].op == CMD_CLR_CYC) exp_cyc = 8'd0;
        end

        // host read of r5 while the scanner selects r3
        next_cycle();
        drive(1'b1, CMD_READ_REG, 32'd5);
        #2;
        chk("rd_t0_ready", 32'(cmd_ready), 32'd1);
        chk("rd_t0_addr",  32'(dbg_reg_addr), 32'd3);
        exp_q.push_back(32'hDEADBEEF);
        next_cycle();
        drive(1'b1, CMD_RUN, 32'd0);
        regs[3] = 32'hA5A5A5A5;
        #2;
        chk("rd_t1_ready", 32'(cmd_ready), 32'd0);
        chk("rd_t1_addr",  32'(dbg_reg_addr), 32'd5);
        chk("rd_t1_rsp",   32'(rsp_valid), 32'd0);
        chk("rd_t1_disp",  disp_data, 32'h03030303);
        next_cycle();
        drive(1'b0, CMD_NOP, 32'd0);
        #2;
        chk("rd_t2_ready", 32'(cmd_ready), 32'd0);
        chk("rd_t2_rsp",   32'(rsp_valid), 32'd1);
        chk("rd_t2_data",  rsp_data, 32'hDEADBEEF);
        chk("rd_t2_addr",  32'(dbg_reg_addr), 32'd3);
        chk("rd_t2_disp",  disp_data, 32'h03030303);
        chk("rd_t2_halt",  32'(halted), 32'd1);
        next_cycle();
        #2;
        chk("rd_t3_ready", 32'(cmd_ready), 32'd1);
        chk("rd_t3_rsp",   32'(rsp_valid), 32'd0);
        chk("rd_t3_disp",  disp_data, 32'hA5A5A5A5);
        chk("rd_t3_data",  rsp_data, 32'hDEADBEEF);
        chk("rd_t3_halt",  32'(halted), 32'd1);

        // register 0 returns the PC
        next_cycle();
        pc = 32'h77;
        drive(1'b1, CMD_READ_REG, 32'd0);
        exp_q.push_back(32'h77);
        next_cycle();
        drive(1'b0, CMD_NOP, 32'd0);
        next_cycle();
        #2;
        chk("rd0_data", rsp_data, 32'h77);

        // cycle counter wrap (CNT_W=8)
        next_cycle();
        pc = 32'h100;
        drive(1'b1, CMD_CLR_CYC, 32'd0);
        next_cycle();
        drive(1'b1, CMD_RUN, 32'd0);
        #2;
        chk("wrap_start", 32'(cycle_cnt), 32'd0);
        next_cycle();
        drive(1'b0, CMD_NOP, 32'd0);
        repeat (255) @(posedge clk);
        #3;
        chk("wrap_max",  32'(cycle_cnt), 32'hFF);
        chk("wrap_en",   32'(cpu_en), 32'd1);
        @(posedge clk);
        #3;
        chk("wrap_zero", 32'(cycle_cnt), 32'd0);
        next_cycle();
        drive(1'b1, CMD_HALT, 32'd0);
        next_cycle();
        drive(1'b0, CMD_NOP, 32'd0);
        #2;
        chk("wrap_halted", 32'(halted), 32'd1);

        // asynchronous reset mid-STEP and mid-read, breakpoint armed
        next_cycle();
        drive(1'b1, CMD_SET_BP, 32'h40);
        next_cycle();
        pc = 32'h30;
        drive(1'b1, CMD_STEP, 32'd7);
        next_cycle();
        drive(1'b0, CMD_NOP, 32'd0);
        next_cycle();
        pc = 32'h31;
        next_cycle();
        pc = 32'h32;
        drive(1'b1, CMD_READ_REG, 32'd5);
        #2;
        chk("ar_step_en", 32'(cpu_en), 32'd1);
        next_cycle();
        drive(1'b0, CMD_NOP, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("ar_cpuEn",    32'(cpu_en), 32'd0);
        chk("ar_halted",   32'(halted), 32'd1);
        chk("ar_ready",    32'(cmd_ready), 32'd1);
        chk("ar_rsp",      32'(rsp_valid), 32'd0);
        chk("ar_cycleCnt", 32'(cycle_cnt), 32'd0);
        chk("ar_rspData",  rsp_data, 32'd0);
        chk("ar_dispData", disp_data, 32'd0);
        chk("ar_addr",     32'(dbg_reg_addr), 32'd3);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #2;
            chk($sformatf("ar_post%0d_rsp", i), 32'(rsp_valid), 32'd0);
        end
        next_cycle();
        pc = 32'h40;
        drive(1'b1, CMD_RUN, 32'd0);
        next_cycle();
        drive(1'b0, CMD_NOP, 32'd0);
        #2;
        chk("ar_bp_c1", 32'(cpu_en), 32'd1);
        next_cycle();
        #2;
        chk("ar_bp_c2",     32'(cpu_en), 32'd1);
        chk("ar_bp_halted", 32'(halted), 32'd0);

        next_cycle();
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
